// File: rtl/rms_rc_scale_gen.sv
// Recompute-scale generator: accumulates the mean square of one activation vector,
// then derives scale = 2^DIV_SHIFT / floor(sqrt(mean)) with bit-serial sqrt and divide.
module rms_rc_scale_gen #(
  parameter int IN_DATA_WIDTH = 24,
  parameter int VEC_LEN       = 64,
  parameter int SCALE_WIDTH   = 16,
  parameter int DIV_SHIFT     = 22
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic signed [IN_DATA_WIDTH-1:0] in_data,
  input  logic                            in_data_vld,
  output logic                            in_data_rdy,
  input  logic                            vec_consumed,
  output logic        [SCALE_WIDTH-1:0]   rc_scale,
  output logic                            rc_scale_vld,
  output logic                            rc_scale_clear,
  output logic                            busy
);

  localparam int LOG2_LEN = $clog2(VEC_LEN);
  localparam int SQ_W     = 2 * IN_DATA_WIDTH;
  localparam int ACC_W    = SQ_W + LOG2_LEN;
  localparam int REM_W    = IN_DATA_WIDTH + 6;
  localparam int DREM_W   = IN_DATA_WIDTH + 2;
  localparam int Q_W      = DIV_SHIFT + 1;
  localparam int STEP_MAX = (IN_DATA_WIDTH > Q_W) ? IN_DATA_WIDTH : Q_W;
  localparam int CNT_W    = $clog2(STEP_MAX + 1);

  localparam logic [Q_W-1:0] SAT_MAX  = Q_W'((2 ** (SCALE_WIDTH - 1)) - 1);
  localparam logic [Q_W-1:0] DVD_INIT = Q_W'(1) << DIV_SHIFT;

  typedef enum logic [1:0] {S_ACC, S_SQRT, S_DIV, S_OUT} state_t;

  function automatic logic signed [SCALE_WIDTH-1:0] sat_scale(input logic [Q_W-1:0] q);
    if (q > SAT_MAX) sat_scale = SAT_MAX[SCALE_WIDTH-1:0];
    else             sat_scale = q[SCALE_WIDTH-1:0];
  endfunction

  state_t                          r_state, w_state_nxt;
  logic        [ACC_W-1:0]         r_acc;
  logic        [LOG2_LEN-1:0]      r_cnt;
  logic        [CNT_W-1:0]         r_step;
  logic signed [SCALE_WIDTH-1:0]   r_scale;
  logic                            r_vld;
  logic                            r_clear;

  logic        [SQ_W-1:0]          r_mean;
  logic signed [REM_W-1:0]         r_srem;
  logic        [IN_DATA_WIDTH-1:0] r_root;
  logic        [DREM_W-1:0]        r_drem;
  logic        [Q_W-1:0]           r_quo;
  logic        [Q_W-1:0]           r_dvd;

  logic                            w_xfer, w_last, w_sqrt_done, w_div_done;
  logic signed [SQ_W-1:0]          w_in_ext, w_sq;
  logic        [ACC_W-1:0]         w_acc_sum;
  logic signed [REM_W-1:0]         w_root_ext, w_trial_sub, w_trial_add;
  logic signed [REM_W-1:0]         w_srem_sh, w_srem_nxt;
  logic        [IN_DATA_WIDTH-1:0] w_root_nxt;
  logic        [DREM_W-1:0]        w_div_ext, w_drem_sh, w_drem_nxt;
  logic                            w_ge;

  // Accumulate stage: signed square widened before the multiply so nothing truncates
  assign w_xfer    = in_data_vld & in_data_rdy;
  assign w_last    = w_xfer && (r_cnt == LOG2_LEN'(VEC_LEN - 1));
  assign w_in_ext  = SQ_W'(in_data);
  assign w_sq      = w_in_ext * w_in_ext;
  assign w_acc_sum = r_acc + {{LOG2_LEN{1'b0}}, w_sq};

  // Sqrt stage: non-restoring, remainder sign selects add/subtract of the trial value
  assign w_root_ext  = signed'({{(REM_W - IN_DATA_WIDTH){1'b0}}, r_root});
  assign w_trial_sub = (w_root_ext <<< 2) | REM_W'(1);
  assign w_trial_add = (w_root_ext <<< 2) | REM_W'(3);
  assign w_srem_sh   = (r_srem <<< 2) | signed'(REM_W'(r_mean[SQ_W-1 -: 2]));
  assign w_srem_nxt  = r_srem[REM_W-1] ? (w_srem_sh + w_trial_add) : (w_srem_sh - w_trial_sub);
  assign w_root_nxt  = {r_root[IN_DATA_WIDTH-2:0], ~w_srem_nxt[REM_W-1]};

  // Divide stage: restoring, dividend bits fed MSB first from r_dvd
  assign w_div_ext  = {{(DREM_W - IN_DATA_WIDTH){1'b0}}, r_root};
  assign w_drem_sh  = (r_drem << 1) | DREM_W'(r_dvd[Q_W-1]);
  assign w_ge       = (w_drem_sh >= w_div_ext);
  assign w_drem_nxt = w_ge ? (w_drem_sh - w_div_ext) : w_drem_sh;

  assign w_sqrt_done = (r_step == CNT_W'(IN_DATA_WIDTH - 1));
  assign w_div_done  = (r_step == CNT_W'(DIV_SHIFT));

  always_comb begin
    w_state_nxt = r_state;
    in_data_rdy = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_ACC: begin
        // Hold off input during the result pulse so a new vector starts afterwards
        in_data_rdy = ~r_vld;
        if (w_last) w_state_nxt = S_SQRT;
      end
      S_SQRT: begin
        busy = 1'b1;
        if (w_sqrt_done) w_state_nxt = S_DIV;
      end
      S_DIV: begin
        busy = 1'b1;
        if (w_div_done) w_state_nxt = S_OUT;
      end
      default: w_state_nxt = S_ACC;
    endcase
    if (flush) w_state_nxt = S_ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_step  <= '0;
      r_scale <= '0;
      r_vld   <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clear <= vec_consumed;
      r_vld   <= 1'b0;
      if (w_state_nxt != r_state) r_step <= '0;
      else if (busy)              r_step <= r_step + 1'b1;
      if (flush) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        if (w_xfer) begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= w_last ? '0 : w_acc_sum;
        end
        if (r_state == S_OUT) begin
          r_scale <= sat_scale(r_quo);
          r_vld   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_ACC: begin
        if (w_last) begin
          r_mean <= w_acc_sum[ACC_W-1:LOG2_LEN];
          r_srem <= '0;
          r_root <= '0;
        end
      end
      S_SQRT: begin
        r_mean <= r_mean << 2;
        r_srem <= w_srem_nxt;
        r_drem <= '0;
        r_dvd  <= DVD_INIT;
        // A zero root would make the divide meaningless; clamp it to one
        if (w_sqrt_done && (w_root_nxt == '0)) r_root <= IN_DATA_WIDTH'(1);
        else                                    r_root <= w_root_nxt;
      end
      S_DIV: begin
        r_drem <= w_drem_nxt;
        r_quo  <= {r_quo[Q_W-2:0], w_ge};
        r_dvd  <= r_dvd << 1;
      end
      default: ;
    endcase
  end

  assign rc_scale       = r_scale;
  assign rc_scale_vld   = r_vld;
  assign rc_scale_clear = r_clear;

endmodule

// File: tb/tb_rms_rc_scale_gen.sv
// Randomized self-checking bench for rms_rc_scale_gen against an arithmetic reference model.
module tb_rms_rc_scale_gen;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic signed [23:0] in_data = '0;
  logic               in_data_vld = 1'b0;
  logic               in_data_rdy;
  logic               vec_consumed = 1'b0;
  logic        [15:0] rc_scale;
  logic               rc_scale_vld;
  logic               rc_scale_clear;
  logic               busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vld_pulses = 0;
  int vec[64];

  rms_rc_scale_gen dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_data_vld(in_data_vld), .in_data_rdy(in_data_rdy),
    .vec_consumed(vec_consumed), .rc_scale(rc_scale), .rc_scale_vld(rc_scale_vld),
    .rc_scale_clear(rc_scale_clear), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rc_scale_vld) vld_pulses <= vld_pulses + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint isqrt(input longint m);
    longint lo = 0, hi = 64'd1 << 24, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= m) lo = mid;
      else                hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic int model_scale();
    longint sum = 0, mean, r, q;
    for (int i = 0; i < 64; i++) sum += longint'(vec[i]) * longint'(vec[i]);
    mean = sum / 64;
    r = isqrt(mean);
    if (r == 0) r = 1;
    q = (64'd1 << 22) / r;
    if (q > 32767) q = 32767;
    return int'(q);
  endfunction

  // Sends vec[0..n-1]; e0 is the cycle stamp sampled just after the last transfer edge
  task automatic send_n(input int n, output int e0, output bit ok);
    int w;
    ok = 1'b1;
    e0 = 0;
    for (int i = 0; i < n; i++) begin
      in_data = vec[i][23:0];
      in_data_vld = 1'b1;
      w = 0;
      while (!in_data_rdy && w < 200) begin tick(); w++; end
      if (w >= 200) begin
        checks++; errors++;
        $display("FAIL send_rdy_timeout element=%0d rdy=%0b required=1", i, in_data_rdy);
        in_data_vld = 1'b0;
        ok = 1'b0;
        return;
      end
      tick();
    end
    in_data_vld = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_result(input int e0, output bit got, output int lat, output int sc,
                             output int rdylow, output int busycnt, output int vldcnt);
    got = 0; lat = -1; sc = -1; rdylow = 0; busycnt = 0; vldcnt = 0;
    for (int k = 0; k < 150; k++) begin
      if (!in_data_rdy) rdylow++;
      if (busy) busycnt++;
      if (rc_scale_vld) begin
        vldcnt++;
        if (!got) begin got = 1; lat = cyc - e0; sc = int'(rc_scale); end
      end
      if (got && in_data_rdy) break;
      tick();
    end
  endtask

  task automatic run_vec(input string name, input bit timing);
    int e0, lat, sc, rdylow, busycnt, vldcnt, exp_sc;
    bit ok, got;
    exp_sc = model_scale();
    send_n(64, e0, ok);
    if (!ok) return;
    wait_result(e0, got, lat, sc, rdylow, busycnt, vldcnt);
    checks++;
    if (got !== 1'b1) begin
      errors++; $display("FAIL %s_vld got=%0b required=1", name, got);
      return;
    end
    checks++;
    if (sc !== exp_sc) begin errors++; $display("FAIL %s_scale got=%0d required=%0d", name, sc, exp_sc); end
    checks++;
    if (vldcnt !== 1) begin errors++; $display("FAIL %s_vld_width got=%0d required=1", name, vldcnt); end
    if (timing) begin
      checks++;
      if (lat !== 48) begin errors++; $display("FAIL %s_latency got=%0d required=48", name, lat); end
      checks++;
      if (rdylow !== 49) begin errors++; $display("FAIL %s_rdy_low got=%0d required=49", name, rdylow); end
      checks++;
      if (busycnt !== 47) begin errors++; $display("FAIL %s_busy_cycles got=%0d required=47", name, busycnt); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_data_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%0b required=1", in_data_rdy); end
    checks++; if (rc_scale !== 16'd0) begin errors++; $display("FAIL reset_scale got=%0d required=0", rc_scale); end
    checks++; if (rc_scale_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%0b required=0", rc_scale_vld); end
    checks++; if (rc_scale_clear !== 1'b0) begin errors++; $display("FAIL reset_clear got=%0b required=0", rc_scale_clear); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b required=0", busy); end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 64; i++) vec[i] = 256;
    run_vec("const256", 1'b1);
    for (int i = 0; i < 64; i++) vec[i] = (i % 2 == 0) ? 1000 : -1000;
    run_vec("alt1000", 1'b1);
    for (int i = 0; i < 64; i++) vec[i] = 0;
    run_vec("zeros_sat", 1'b0);
    for (int i = 0; i < 64; i++) vec[i] = -8388608;
    run_vec("max_neg", 1'b0);
  endtask

  task automatic test_random();
    int shifts[4] = '{8, 14, 20, 28};
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 64; i++) vec[i] = int'($urandom) >>> shifts[t];
      run_vec($sformatf("random%0d", t), 1'b1);
    end
  endtask

  task automatic test_flush_acc();
    int e0, p0;
    bit ok;
    p0 = vld_pulses;
    for (int i = 0; i < 64; i++) vec[i] = 1000;
    send_n(30, e0, ok);
    flush = 1'b1; in_data = 24'sd30000; in_data_vld = 1'b1;
    tick();
    flush = 1'b0; in_data_vld = 1'b0;
    for (int i = 0; i < 64; i++) vec[i] = 256;
    run_vec("flush_acc", 1'b1);
    checks++;
    if (vld_pulses - p0 !== 1) begin errors++; $display("FAIL flush_acc_pulses got=%0d required=1", vld_pulses - p0); end
  endtask

  task automatic test_flush_sqrt();
    int e0, p0, prev;
    bit ok;
    prev = int'(rc_scale);
    p0 = vld_pulses;
    for (int i = 0; i < 64; i++) vec[i] = int'($urandom) >>> 12;
    send_n(64, e0, ok);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (in_data_rdy !== 1'b1) begin errors++; $display("FAIL flush_sqrt_rdy got=%0b required=1", in_data_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_sqrt_busy got=%0b required=0", busy); end
    repeat (60) tick();
    checks++;
    if (vld_pulses - p0 !== 0) begin errors++; $display("FAIL flush_sqrt_pulses got=%0d required=0", vld_pulses - p0); end
    checks++;
    if (int'(rc_scale) !== prev) begin errors++; $display("FAIL flush_sqrt_scale_hold got=%0d required=%0d", rc_scale, prev); end
  endtask

  task automatic test_reset_mid();
    int e0, p0;
    bit ok;
    for (int i = 0; i < 64; i++) vec[i] = 777;
    send_n(64, e0, ok);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got=%0b required=0", busy); end
    tick();
    rst_n = 1'b1;
    p0 = vld_pulses;
    repeat (60) tick();
    checks++;
    if (vld_pulses - p0 !== 0) begin errors++; $display("FAIL reset_mid_pulses got=%0d required=0", vld_pulses - p0); end
    checks++; if (rc_scale !== 16'd0) begin errors++; $display("FAIL reset_mid_scale got=%0d required=0", rc_scale); end
  endtask

  task automatic test_clear();
    int e0, sc;
    bit ok;
    vec_consumed = 1'b1;
    tick();
    vec_consumed = 1'b0;
    checks++; if (rc_scale_clear !== 1'b1) begin errors++; $display("FAIL clear_pulse got=%0b required=1", rc_scale_clear); end
    tick();
    checks++; if (rc_scale_clear !== 1'b0) begin errors++; $display("FAIL clear_width got=%0b required=0", rc_scale_clear); end
    for (int i = 0; i < 64; i++) vec[i] = (i % 2 == 0) ? -1000 : 1000;
    sc = model_scale();
    send_n(64, e0, ok);
    repeat (47) tick();
    vec_consumed = 1'b1;
    tick();
    vec_consumed = 1'b0;
    checks++;
    if ({rc_scale_vld, rc_scale_clear} !== 2'b11) begin
      errors++; $display("FAIL coincide_vld_clear got=%b required=11", {rc_scale_vld, rc_scale_clear});
    end
    checks++; if (int'(rc_scale) !== sc) begin errors++; $display("FAIL coincide_scale got=%0d required=%0d", rc_scale, sc); end
    tick();
    checks++;
    if ({rc_scale_vld, rc_scale_clear} !== 2'b00) begin
      errors++; $display("FAIL coincide_after got=%b required=00", {rc_scale_vld, rc_scale_clear});
    end
  endtask

  task automatic test_back_to_back();
    int e0a, e0b, p0;
    bit ok;
    p0 = vld_pulses;
    for (int i = 0; i < 64; i++) vec[i] = int'($urandom) >>> 10;
    send_n(64, e0a, ok);
    for (int i = 0; i < 64; i++) vec[i] = int'($urandom) >>> 16;
    run_b2b_second(e0a, p0);
  endtask

  task automatic run_b2b_second(input int e0a, input int p0);
    int e0b, lat, sc, rdylow, busycnt, vldcnt, exp_sc;
    bit ok, got;
    exp_sc = model_scale();
    send_n(64, e0b, ok);
    checks++;
    if (e0b - e0a !== 113) begin errors++; $display("FAIL b2b_period got=%0d required=113", e0b - e0a); end
    wait_result(e0b, got, lat, sc, rdylow, busycnt, vldcnt);
    checks++; if (sc !== exp_sc) begin errors++; $display("FAIL b2b_scale got=%0d required=%0d", sc, exp_sc); end
    checks++;
    if (vld_pulses - p0 !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d required=2", vld_pulses - p0); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush_acc();
    test_flush_sqrt();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
